// File: rtl/lane_merge2x1_pkg.sv
// lane_merge2x1 shared definitions: width/depth defaults,
// merge state encoding and the log2 helper used to size pointers.
package lane_merge2x1_pkg;

    localparam int BW_DEF    = 8;
    localparam int DEPTH_DEF = 4;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int AW_DEF = clog2(DEPTH_DEF);

endpackage

// File: rtl/lane_merge2x1_fifo.sv
// lane_fifo: per-lane synchronous FIFO with occupancy counter.
// No fall-through; head is always the registered entry at rd_ptr.
module lane_fifo
    import lane_merge2x1_pkg::*;
#(
    parameter int BW    = BW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [BW-1:0] wr_data,
    input  logic          rd_en,
    output logic [BW-1:0] rd_data,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [BW-1:0] mem_q [DEPTH];
    logic [BW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);

endmodule

// File: rtl/lane_merge2x1.sv
// lane_merge2x1: buffers two demuxed byte lanes and re-serialises
// them in strict lane0/lane1 order onto one valid/ready stream.
module lane_merge2x1
    import lane_merge2x1_pkg::*;
#(
    parameter int BW    = BW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [BW-1:0] in0,
    input  logic [BW-1:0] in1,
    input  logic [1:0]    valid_in,
    input  logic          ready,
    output logic [BW-1:0] out,
    output logic          valid_out,
    output logic [1:0]    fifo_full,
    output logic [1:0]    fifo_empty,
    output logic          overflow_err
);

    lane_e         state_q, state_d;
    logic [BW-1:0] out_q, out_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;

    logic          load_ok;
    logic          cur_empty;
    logic          pop;
    logic [1:0]    pop_lane;
    logic [1:0]    wr_en;
    logic [BW-1:0] head0, head1;

    lane_fifo #(.BW(BW), .DEPTH(DEPTH), .AW(AW)) u_fifo0 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en[0]),
        .wr_data (in0),
        .rd_en   (pop_lane[0]),
        .rd_data (head0),
        .full    (fifo_full[0]),
        .empty   (fifo_empty[0])
    );

    lane_fifo #(.BW(BW), .DEPTH(DEPTH), .AW(AW)) u_fifo1 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en[1]),
        .wr_data (in1),
        .rd_en   (pop_lane[1]),
        .rd_data (head1),
        .full    (fifo_full[1]),
        .empty   (fifo_empty[1])
    );

    assign load_ok   = !valid_q || ready;
    assign cur_empty = (state_q == LANE0) ? fifo_empty[0] : fifo_empty[1];
    assign pop       = load_ok && !cur_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LANE0;
        end else begin
            state_q <= state_d;
        end
    end

    // Never skip a lane: only a pop advances the merge pointer.
    always_comb begin
        state_d = state_q;
        if (pop) begin
            state_d = (state_q == LANE0) ? LANE1 : LANE0;
        end
    end

    always_comb begin
        pop_lane = 2'b00;
        out_d    = out_q;
        valid_d  = valid_q;
        unique case ({load_ok, cur_empty})
            2'b10: begin
                pop_lane[0] = (state_q == LANE0);
                pop_lane[1] = (state_q == LANE1);
                out_d       = (state_q == LANE0) ? head0 : head1;
                valid_d     = 1'b1;
            end
            2'b11: begin
                valid_d = 1'b0;
            end
            default: begin
                valid_d = valid_q;
            end
        endcase
    end

    // A full lane still accepts if it is being popped this cycle.
    always_comb begin
        wr_en = valid_in & (~fifo_full | pop_lane);
        ovf_d = ovf_q | (|(valid_in & ~wr_en));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out          = out_q;
    assign valid_out    = valid_q;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_lane_merge2x1.sv
// Scoreboard bench for lane_merge2x1: directed vectors push expected
// bytes; a negedge monitor pops and compares on every handshake.
module tb_lane_merge2x1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in0, in1;
    logic [1:0] valid_in;
    logic       ready;
    logic [7:0] out;
    logic       valid_out;
    logic [1:0] fifo_full, fifo_empty;
    logic       overflow_err;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_b;

    lane_merge2x1 dut (
        .clk          (clk),
        .reset        (rst_n),
        .in0          (in0),
        .in1          (in1),
        .valid_in     (valid_in),
        .ready        (ready),
        .out          (out),
        .valid_out    (valid_out),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && valid_out && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %0h expected none", out);
            end else begin
                exp_b = exp_q.pop_front();
                chk("merge_order", {24'h0, out}, {24'h0, exp_b});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] a,
                         input logic [7:0] b);
        valid_in = v;
        in0      = a;
        in1      = b;
    endtask

    task automatic push(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    task automatic apply_reset();
        drive(2'b00, 8'h00, 8'h00);
        ready = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        ready = 1'b0;
        drive(2'b00, 8'h00, 8'h00);
        #12;
        chk("rst_out", {valid_out, out}, 9'h000);
        chk("rst_empty", fifo_empty, 2'b11);
        chk("rst_full", fifo_full, 2'b00);
        chk("rst_ovf", overflow_err, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        // mid-stream reset
        ready = 1'b1;
        push(8'h21); push(8'hA1); push(8'h22);
        push(8'hA2); push(8'h23); push(8'hA3);
        drive(2'b11, 8'h21, 8'hA1); step();
        drive(2'b11, 8'h22, 8'hA2); step();
        drive(2'b11, 8'h23, 8'hA3); step();
        drive(2'b00, 8'h00, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out", {valid_out, out}, 9'h000);
        chk("midrst_empty", fifo_empty, 2'b11);
        chk("midrst_ovf", overflow_err, 1'b0);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
        push(8'h31); push(8'hB1);
        drive(2'b11, 8'h31, 8'hB1); step();
        drive(2'b00, 8'h00, 8'h00); step();
        chk("post_rst_first", {valid_out, out}, {1'b1, 8'h31});
        wait_drain("post_rst_drain");

        // ordered merge
        apply_reset();
        ready = 1'b1;
        push(8'hA0); push(8'hA1); push(8'hB0); push(8'hB1);
        drive(2'b11, 8'hA0, 8'hA1); step();
        chk("no_fallthrough", valid_out, 1'b0);
        drive(2'b11, 8'hB0, 8'hB1); step();
        chk("ord_a0", {valid_out, out}, {1'b1, 8'hA0});
        drive(2'b00, 8'h00, 8'h00); step();
        chk("ord_a1", {valid_out, out}, {1'b1, 8'hA1});
        step();
        chk("ord_b0", {valid_out, out}, {1'b1, 8'hB0});
        step();
        chk("ord_b1", {valid_out, out}, {1'b1, 8'hB1});
        wait_drain("ord_drain");

        // lane skew
        apply_reset();
        ready = 1'b1;
        push(8'h00); push(8'h11); push(8'h01); push(8'h12);
        drive(2'b10, 8'h00, 8'h11); step();
        drive(2'b10, 8'h00, 8'h12); step();
        drive(2'b00, 8'h00, 8'h00); step();
        chk("skew_stall", valid_out, 1'b0);
        step();
        chk("skew_stall2", valid_out, 1'b0);
        drive(2'b01, 8'h00, 8'h00); step();
        drive(2'b01, 8'h01, 8'h00); step();
        drive(2'b00, 8'h00, 8'h00);
        wait_drain("skew_drain");

        // backpressure and overflow
        apply_reset();
        ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            drive(2'b11, 8'(i), 8'(8'h80 + i));
            step();
            if (i >= 2) chk("bp_hold", {valid_out, out}, {1'b1, 8'h01});
        end
        drive(2'b00, 8'h00, 8'h00);
        chk("bp_full", fifo_full, 2'b11);
        chk("bp_ovf", overflow_err, 1'b1);
        step();
        chk("bp_hold_idle", {valid_out, out}, {1'b1, 8'h01});
        push(8'h01); push(8'h81); push(8'h02); push(8'h82); push(8'h03);
        push(8'h83); push(8'h04); push(8'h84); push(8'h05);
        ready = 1'b1;
        wait_drain("bp_drain");
        step();
        step();
        chk("bp_tail_idle", valid_out, 1'b0);
        chk("bp_ovf_sticky", overflow_err, 1'b1);

        // full lane with concurrent pop
        apply_reset();
        ready = 1'b0;
        push(8'h10); push(8'h90); push(8'h11); push(8'h91); push(8'h12);
        push(8'h92); push(8'h13); push(8'h93); push(8'h14);
        drive(2'b11, 8'h10, 8'h90); step();
        drive(2'b11, 8'h11, 8'h91); step();
        drive(2'b11, 8'h12, 8'h92); step();
        drive(2'b11, 8'h13, 8'h93); step();
        chk("fp_full_pre", fifo_full, 2'b10);
        ready = 1'b1;
        drive(2'b01, 8'h14, 8'h00); step();
        chk("fp_full0", fifo_full, 2'b01);
        drive(2'b01, 8'h15, 8'h00); step();
        chk("fp_still_full", fifo_full[0], 1'b1);
        chk("fp_no_ovf", overflow_err, 1'b0);
        drive(2'b00, 8'h00, 8'h00);
        wait_drain("fp_drain");

        // wrap-around at half rate per lane
        apply_reset();
        ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push(8'(i + 1));
            push(8'(8'h40 + i));
            drive(2'b11, 8'(i + 1), 8'(8'h40 + i)); step();
            drive(2'b00, 8'h00, 8'h00); step();
        end
        wait_drain("wrap_drain");
        chk("wrap_no_ovf", overflow_err, 1'b0);
        step();
        step();
        chk("wrap_empty", fifo_empty, 2'b11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
